ahb_param_slave: RTL and testbench
==================================

AHB_PARAM_SLAVE -- requirements
Module: ahb_param_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, HADDR width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, HWDATA/HRDATA width; legal values 32 and 64.
REQ-003 SHALL have parameter DEPTH, default 256, memory depth in DATA_W-wide words.
REQ-004 SHALL have parameter WAIT_CYC, default 0, wait states inserted per transfer; legal range 0..15.
REQ-005 SHALL have parameter BASE_ADDR, default 0, byte address of word 0; aligned to DATA_W/8.
REQ-006 SHALL have port HCLK, input, 1, single clock; all logic rising-edge.
REQ-007 SHALL have port HRESET, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port HSEL, input, 1, slave select.
REQ-009 SHALL have port HADDR, input, ADDR_W, byte address.
REQ-010 SHALL have port HTRANS, input, 2, IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-011 SHALL have port HWRITE, input, 1, 1=write, 0=read.
REQ-012 SHALL have port HSIZE, input, 3, transfer size 2^HSIZE bytes.
REQ-013 SHALL have port HBURST, input, 3, burst type; accepted, not decoded.
REQ-014 SHALL have port HWDATA, input, DATA_W, write data, valid in data phase.
REQ-015 SHALL have port HREADY, input, 1, bus-level ready.
REQ-016 SHALL have port HRDATA, output, DATA_W, read data.
REQ-017 SHALL have port HREADYOUT, output, 1, slave ready.
REQ-018 SHALL have port HRESP, output, 1, 0=OKAY, 1=ERROR.

Function
REQ-019 SHALL accept an address phase only when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; all controls are registered at that edge.
REQ-020 SHALL respond to IDLE or BUSY, or HSEL=0, with zero-wait OKAY and no memory access.
REQ-021 SHALL implement states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-022 Transitions SHALL be: IDLE->WAIT on accept when WAIT_CYC>0; IDLE->DATA when WAIT_CYC=0; WAIT->DATA after WAIT_CYC cycles with HREADYOUT=0; DATA->DATA on a pipelined accept; otherwise DATA->IDLE.
REQ-023 In DATA, HREADYOUT SHALL be 1 and HRESP SHALL be 0.
REQ-024 A read SHALL drive the full addressed word on HRDATA in DATA; HRDATA SHALL be 0 in all other cycles.
REQ-025 A write SHALL update memory at the DATA-cycle edge using HWDATA byte lanes selected by HSIZE and HADDR[log2(DATA_W/8)-1:0], little-endian; unselected bytes SHALL be unchanged.
REQ-026 A read whose data phase immediately follows a write to the same word SHALL return the newly written bytes (forwarding).
REQ-027 An error SHALL be raised for any of: address outside BASE_ADDR..BASE_ADDR+DEPTH*DATA_W/8-1; HADDR not a multiple of 2^HSIZE; 2^HSIZE > DATA_W/8.
REQ-028 On error the block SHALL enter ERR1 (HRESP=1, HREADYOUT=0), then ERR2 (HRESP=1, HREADYOUT=1), then IDLE or a new accept; memory SHALL NOT be written; HRDATA SHALL be 0.
REQ-029 Errors SHALL skip wait states; WAIT_CYC applies only to OKAY transfers.
REQ-030 The wait counter SHALL be 4 bits, loaded at accept and decremented in WAIT.
REQ-031 An address phase presented while HREADYOUT=0 SHALL be ignored (HREADY=0 at bus level).
REQ-032 Deassertion of HSEL during WAIT SHALL NOT abort the in-flight data phase.

Reset
REQ-033 While HRESET=1, state SHALL be IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, and the wait counter SHALL be 0, asynchronously.
REQ-034 Memory contents SHALL NOT be reset; a write in flight when HRESET asserts SHALL be discarded.
REQ-035 The first accept SHALL be possible on the first HCLK rising edge after HRESET deasserts.

Verification
REQ-036 WAIT_CYC=0: NONSEQ write of 0xDEADBEEF to 0x10, then read of 0x10 -> HRDATA=0xDEADBEEF with HREADYOUT=1 in the read data phase, no stall.
REQ-037 WAIT_CYC=3: single read -> HREADYOUT=0 for exactly 3 cycles, then 1 with data and HRESP=0.
REQ-038 Word 0x20 holds 0x11223344; byte write 0xAA to 0x21 (HSIZE=0) -> readback 0x1122AA44.
REQ-039 Read of 0x400 with DEPTH=256 and DATA_W=32, and halfword write to 0x3 -> each gives HRESP=1,HREADYOUT=0 then HRESP=1,HREADYOUT=1; target memory unchanged.
REQ-040 INCR4 burst NONSEQ+SEQ writes 1,2,3,4 to 0x0..0xC with a BUSY inserted, then INCR4 read -> returns 1,2,3,4; BUSY gives an OKAY zero-wait response.
REQ-041 HRESET asserted mid-WAIT on a write -> outputs return to reset values immediately; target word unchanged after reset.

Source files
------------

// File: rtl/ahb_param_slave.sv
// AHB-Lite memory slave: parameterised width, depth, base address and wait states.
// All outputs are registered. A read that directly follows a write to the same word is forwarded.
module ahb_param_slave #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int WAIT_CYC  = 0,
  parameter int BASE_ADDR = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LP_SPAN = (ADDR_W+1)'(DEPTH * NB);
  localparam logic [3:0]        LP_WAIT = 4'(WAIT_CYC);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [IDX_W-1:0]  r_idx;
  logic [NB-1:0]     r_mask;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept, w_err, w_in_range, w_oversize, w_unaligned;
  logic              w_mem_we, w_fwd, w_unused;
  logic [ADDR_W-1:0] w_off_addr;
  logic [IDX_W-1:0]  w_idx;
  logic [OFF_W-1:0]  w_byte_off, w_align_mask;
  logic [NB-1:0]     w_size_mask, w_mask;
  logic [DATA_W-1:0] w_rd_word;

  // HREADYOUT in the accept term keeps an address phase offered during our own stall from being taken.
  assign w_accept    = HSEL & HREADY & HREADYOUT & HTRANS[1];
  assign w_off_addr  = HADDR - LP_BASE;
  assign w_idx       = w_off_addr[OFF_W +: IDX_W];
  assign w_byte_off  = w_off_addr[OFF_W-1:0];
  assign w_in_range  = (HADDR >= LP_BASE) && ({1'b0, w_off_addr} < LP_SPAN);
  assign w_oversize  = HSIZE > 3'(OFF_W);
  assign w_unaligned = |(w_byte_off & w_align_mask);
  assign w_err       = !w_in_range | w_oversize | w_unaligned;
  assign w_mask      = w_size_mask << w_byte_off;
  assign w_mem_we    = (r_state == S_DATA) & r_write;
  assign w_fwd       = w_mem_we & (r_idx == w_idx);
  assign w_unused    = ^{HBURST, HTRANS[0]};

  always_comb begin
    w_size_mask  = '0;
    w_align_mask = '0;
    for (int b = 0; b < NB; b++) w_size_mask[b] = (b >> HSIZE) == 0;
    for (int i = 0; i < OFF_W; i++) w_align_mask[i] = i < int'(HSIZE);
  end

  always_comb begin
    w_rd_word = r_mem[w_idx];
    for (int b = 0; b < NB; b++)
      if (w_fwd && r_mask[b]) w_rd_word[8*b +: 8] = HWDATA[8*b +: 8];
  end

  always_ff @(posedge HCLK) begin
    if (w_mem_we)
      for (int b = 0; b < NB; b++)
        if (r_mask[b]) r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_idx     <= '0;
      r_mask    <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_state   <= S_DATA;
            r_cnt     <= '0;
            HREADYOUT <= 1'b1;
            HRDATA    <= r_write ? '0 : r_mem[r_idx];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          r_state   <= S_ERR2;
          HREADYOUT <= 1'b1;
        end
        default: begin
          if (w_accept) begin
            r_write <= HWRITE & !w_err;
            r_idx   <= w_idx;
            r_mask  <= w_mask;
            if (w_err) begin
              r_state   <= S_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
              HRDATA    <= '0;
            end else if (LP_WAIT != 4'd0) begin
              r_state   <= S_WAIT;
              r_cnt     <= LP_WAIT;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b0;
              HRDATA    <= '0;
            end else begin
              r_state   <= S_DATA;
              HREADYOUT <= 1'b1;
              HRESP     <= 1'b0;
              HRDATA    <= HWRITE ? '0 : w_rd_word;
            end
          end else begin
            r_state   <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_param_slave.sv
// Directed bench for ahb_param_slave: one zero-wait instance and one three-wait instance.
module tb_ahb_param_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hsel0, hsel3, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [31:0] hrdata0, hrdata3;
  logic        hro0, hro3, hresp0, hresp3;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb_param_slave #(.WAIT_CYC(0)) u_dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hro0),
    .HRDATA(hrdata0), .HREADYOUT(hro0), .HRESP(hresp0));

  ahb_param_slave #(.WAIT_CYC(3)) u_dut3 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hro3),
    .HRDATA(hrdata3), .HREADYOUT(hro3), .HRESP(hresp3));

  task automatic idle_bus();
    hsel0 = 0; hsel3 = 0; htrans = 2'b00; hwrite = 0; haddr = '0; hsize = 3'd2; hburst = 3'd0;
  endtask

  // One isolated transfer; starts and ends just after a rising edge with the bus ready.
  task automatic xfer(input bit use3, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata, output int stalls,
                      output logic resp_first, output logic resp_last, output logic [31:0] stall_rd);
    hsel0 = !use3; hsel3 = use3; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
    @(posedge clk); #1;
    idle_bus();
    hwdata = wdata;
    stalls = 0; stall_rd = '0;
    resp_first = use3 ? hresp3 : hresp0;
    while (!(use3 ? hro3 : hro0) && stalls < 40) begin
      stall_rd |= use3 ? hrdata3 : hrdata0;
      stalls++;
      @(posedge clk); #1;
    end
    resp_last = use3 ? hresp3 : hresp0;
    rdata     = use3 ? hrdata3 : hrdata0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst = 1; #1;
    checks++; if (hro0 !== 1'b1) begin errors++; $display("FAIL rst_ready0: got %b expected 1", hro0); end
    checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL rst_resp0: got %b expected 0", hresp0); end
    checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL rst_rdata0: got %h expected 0", hrdata0); end
    checks++; if (hro3 !== 1'b1) begin errors++; $display("FAIL rst_ready3: got %b expected 1", hro3); end
    checks++; if (hrdata3 !== 32'h0) begin errors++; $display("FAIL rst_rdata3: got %h expected 0", hrdata3); end
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_basic();
    logic [31:0] rd, sr; int st; logic rf, rl;
    xfer(0, 1, 32'h10, 3'd2, 32'hDEADBEEF, rd, st, rf, rl, sr);
    checks++; if (st != 0) begin errors++; $display("FAIL basic_wr_stalls: got %0d expected 0", st); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL basic_wr_rdata: got %h expected 0", rd); end
    xfer(0, 0, 32'h10, 3'd2, 32'h0, rd, st, rf, rl, sr);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rdata: got %h expected deadbeef", rd); end
    checks++; if (st != 0) begin errors++; $display("FAIL basic_rd_stalls: got %0d expected 0", st); end
    checks++; if (rl !== 1'b0) begin errors++; $display("FAIL basic_resp: got %b expected 0", rl); end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd, sr; int st; logic rf, rl;
    xfer(0, 1, 32'h20, 3'd2, 32'h11223344, rd, st, rf, rl, sr);
    xfer(0, 1, 32'h21, 3'd0, 32'h0000AA00, rd, st, rf, rl, sr);
    xfer(0, 0, 32'h20, 3'd2, 32'h0, rd, st, rf, rl, sr);
    checks++; if (rd !== 32'h1122AA44) begin errors++; $display("FAIL byte_write: got %h expected 1122aa44", rd); end
    xfer(0, 1, 32'h22, 3'd1, 32'hBEEF0000, rd, st, rf, rl, sr);
    xfer(0, 0, 32'h20, 3'd2, 32'h0, rd, st, rf, rl, sr);
    checks++; if (rd !== 32'hBEEFAA44) begin errors++; $display("FAIL half_write: got %h expected beefaa44", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, sr; int st; logic rf, rl;
    xfer(0, 1, 32'h28, 3'd2, 32'hCAFEF00D, rd, st, rf, rl, sr);
    hsel0 = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h2A; hsize = 3'd1;
    @(posedge clk); #1;
    checks++; if (hro0 !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready: got %b expected 1", hro0); end
    hwdata = 32'h12340000; hwrite = 0; haddr = 32'h28; hsize = 3'd2;
    @(posedge clk); #1;
    idle_bus();
    checks++; if (hrdata0 !== 32'h1234F00D) begin errors++; $display("FAIL b2b_forward: got %h expected 1234f00d", hrdata0); end
    checks++; if (hro0 !== 1'b1) begin errors++; $display("FAIL b2b_rd_ready: got %b expected 1", hro0); end
    @(posedge clk); #1;
    xfer(0, 0, 32'h28, 3'd2, 32'h0, rd, st, rf, rl, sr);
    checks++; if (rd !== 32'h1234F00D) begin errors++; $display("FAIL b2b_mem: got %h expected 1234f00d", rd); end
  endtask

  task automatic test_wait();
    logic [31:0] rd, sr; int st; logic rf, rl;
    xfer(1, 1, 32'h30, 3'd2, 32'h55AA55AA, rd, st, rf, rl, sr);
    checks++; if (st != 3) begin errors++; $display("FAIL wait_wr_stalls: got %0d expected 3", st); end
    xfer(1, 0, 32'h30, 3'd2, 32'h0, rd, st, rf, rl, sr);
    checks++; if (st != 3) begin errors++; $display("FAIL wait_rd_stalls: got %0d expected 3", st); end
    checks++; if (rf !== 1'b0) begin errors++; $display("FAIL wait_stall_resp: got %b expected 0", rf); end
    checks++; if (sr !== 32'h0) begin errors++; $display("FAIL wait_stall_rdata: got %h expected 0", sr); end
    checks++; if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL wait_rdata: got %h expected 55aa55aa", rd); end
    checks++; if (rl !== 1'b0) begin errors++; $display("FAIL wait_resp: got %b expected 0", rl); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, sr; int st; logic rf, rl;
    xfer(0, 1, 32'h0, 3'd2, 32'h01020304, rd, st, rf, rl, sr);
    xfer(0, 0, 32'h400, 3'd2, 32'h0, rd, st, rf, rl, sr);
    checks++; if (st != 1) begin errors++; $display("FAIL err_range_stalls: got %0d expected 1", st); end
    checks++; if (rf !== 1'b1) begin errors++; $display("FAIL err_range_resp1: got %b expected 1", rf); end
    checks++; if (rl !== 1'b1) begin errors++; $display("FAIL err_range_resp2: got %b expected 1", rl); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_range_rdata: got %h expected 0", rd); end
    xfer(0, 1, 32'h3, 3'd1, 32'hFFFFFFFF, rd, st, rf, rl, sr);
    checks++; if (st != 1 || rf !== 1'b1 || rl !== 1'b1) begin errors++;
      $display("FAIL err_align: got stalls=%0d resp=%b/%b expected 1 1/1", st, rf, rl); end
    xfer(0, 0, 32'h0, 3'd2, 32'h0, rd, st, rf, rl, sr);
    checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL err_mem_kept: got %h expected 01020304", rd); end
    xfer(0, 0, 32'h8, 3'd3, 32'h0, rd, st, rf, rl, sr);
    checks++; if (rl !== 1'b1) begin errors++; $display("FAIL err_oversize: got %b expected 1", rl); end
    xfer(0, 0, 32'h3FC, 3'd2, 32'h0, rd, st, rf, rl, sr);
    checks++; if (rl !== 1'b0 || st != 0) begin errors++;
      $display("FAIL last_word_ok: got resp=%b stalls=%0d expected 0 0", rl, st); end
    xfer(1, 0, 32'h400, 3'd2, 32'h0, rd, st, rf, rl, sr);
    checks++; if (st != 1 || rl !== 1'b1) begin errors++;
      $display("FAIL err_skip_wait: got stalls=%0d resp=%b expected 1 1", st, rl); end
  endtask

  task automatic test_burst();
    hburst = 3'd3; hsel0 = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h0; hsize = 3'd2;
    @(posedge clk); #1;
    hwdata = 32'd1; htrans = 2'b11; haddr = 32'h4;
    @(posedge clk); #1;
    hwdata = 32'd2; htrans = 2'b01; haddr = 32'h8;
    @(posedge clk); #1;
    checks++; if (hro0 !== 1'b1 || hresp0 !== 1'b0) begin errors++;
      $display("FAIL busy_okay: got ready=%b resp=%b expected 1 0", hro0, hresp0); end
    htrans = 2'b11; haddr = 32'h8;
    @(posedge clk); #1;
    hwdata = 32'd3; haddr = 32'hC;
    @(posedge clk); #1;
    hwdata = 32'd4; idle_bus();
    @(posedge clk); #1;
    hburst = 3'd3; hsel0 = 1; htrans = 2'b10; hwrite = 0; haddr = 32'h0; hsize = 3'd2;
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (hrdata0 !== 32'(i) || hro0 !== 1'b1) begin errors++;
        $display("FAIL burst_rd%0d: got %h ready=%b expected %h ready=1", i, hrdata0, hro0, 32'(i)); end
      if (i < 4) begin htrans = 2'b11; haddr = 32'(4 * i); end
      else idle_bus();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd, sr; int st; logic rf, rl;
    xfer(1, 1, 32'h40, 3'd2, 32'h0BADF00D, rd, st, rf, rl, sr);
    hsel3 = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h40; hsize = 3'd2;
    @(posedge clk); #1;
    idle_bus(); hwdata = 32'hFFFFFFFF;
    checks++; if (hro3 !== 1'b0) begin errors++; $display("FAIL midrst_in_wait: got %b expected 0", hro3); end
    @(posedge clk); #1;
    rst = 1; #1;
    checks++; if (hro3 !== 1'b1 || hresp3 !== 1'b0 || hrdata3 !== 32'h0) begin errors++;
      $display("FAIL midrst_outputs: got ready=%b resp=%b rdata=%h expected 1 0 0", hro3, hresp3, hrdata3); end
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 0;
    xfer(1, 0, 32'h40, 3'd2, 32'h0, rd, st, rf, rl, sr);
    checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL midrst_mem: got %h expected 0badf00d", rd); end
    checks++; if (st != 3) begin errors++; $display("FAIL midrst_stalls: got %0d expected 3", st); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_bus();
    hwdata = '0;
    test_reset();
    test_basic();
    test_byte_write();
    test_back_to_back();
    test_wait();
    test_errors();
    test_burst();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
